// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch from a loadable program memory into a registered
// valid/ready output stage, with redirect, halt/resume and a sticky range fault.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              start,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic              fault,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10,
    S_FAULT  = 2'b11
  } state_t;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2^ADDR_W is representable and never trips the range check.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pc;
  state_t            st;

  logic             stage_free;
  logic             pc_oob;
  logic             prog_ok;
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] wr_idx;

  assign stage_free = !out_valid || out_ready;
  assign pc_oob     = {1'b0, pc} >= DEPTH_X;
  assign prog_ok    = {1'b0, prog_addr} < DEPTH_X;
  assign pc_idx     = pc[IDX_W-1:0];
  assign wr_idx     = prog_addr[IDX_W-1:0];
  assign state      = st;

  // Program memory has no reset so its contents survive a core reset.
  always_ff @(posedge clk) begin
    if (reset && st == S_IDLE && prog_we && prog_ok) begin
      mem[wr_idx] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= S_IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      fault     <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (redirect) pc <= redirect_pc;
          if (start)    st <= S_RUN;
        end
        S_RUN: begin
          if (halt) begin
            st <= S_HALTED;
            if (stage_free) out_valid <= 1'b0;
          end else if (redirect) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
          end else if (stage_free) begin
            if (pc_oob) begin
              st        <= S_FAULT;
              fault     <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              out_instr <= mem[pc_idx];
              out_pc    <= pc;
              out_valid <= 1'b1;
              pc        <= pc + 1'b1;
            end
          end
        end
        S_HALTED: begin
          // A word stalled at halt time stays visible until downstream takes it.
          if (redirect) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
          if (start) st <= S_RUN;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Drives a DEPTH=20 and a DEPTH=256 fetch unit with identical stimulus and checks
// both against directed expectations and a rule-level reference model.
module tb_instr_fetch_unit;

  localparam int N = 2;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_HALT = 2, ST_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        start = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        halt = 1'b0;
  logic        out_ready = 1'b0;

  logic        d_ov  [N];
  logic [7:0]  d_pc  [N];
  logic [31:0] d_ins [N];
  logic        d_flt [N];
  logic [1:0]  d_st  [N];

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(32), .DEPTH(20), .RESET_PC(8'd0)) u_d20 (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .out_ready(out_ready),
    .out_valid(d_ov[0]), .out_pc(d_pc[0]), .out_instr(d_ins[0]),
    .fault(d_flt[0]), .state(d_st[0]));

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .RESET_PC(8'd0)) u_d256 (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .out_ready(out_ready),
    .out_valid(d_ov[1]), .out_pc(d_pc[1]), .out_instr(d_ins[1]),
    .fault(d_flt[1]), .state(d_st[1]));

  // Reference model state
  int          m_depth [N] = '{20, 256};
  logic [31:0] m_mem [N][256];
  int          m_pc  [N];
  int          m_st  [N];
  logic        m_ov  [N];
  int          m_opc [N];
  logic [31:0] m_oin [N];
  logic        m_flt [N];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_v;
    logic [7:0]  exp_pc;
    logic [31:0] exp_instr;
  } vec_t;
  vec_t tbl [5];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step_model(int i);
    bit free;
    if (!reset) begin
      m_st[i] = ST_IDLE; m_pc[i] = 0; m_ov[i] = 1'b0;
      m_opc[i] = 0; m_oin[i] = '0; m_flt[i] = 1'b0;
      return;
    end
    free = !m_ov[i] || out_ready;
    case (m_st[i])
      ST_IDLE: begin
        if (prog_we && int'(prog_addr) < m_depth[i]) m_mem[i][prog_addr] = prog_data;
        if (redirect) m_pc[i] = int'(redirect_pc);
        if (start) m_st[i] = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          m_st[i] = ST_HALT;
          if (free) m_ov[i] = 1'b0;
        end else if (redirect) begin
          m_pc[i] = int'(redirect_pc);
          m_ov[i] = 1'b0;
        end else if (free) begin
          if (m_pc[i] >= m_depth[i]) begin
            m_st[i] = ST_FAULT; m_flt[i] = 1'b1; m_ov[i] = 1'b0;
          end else begin
            m_oin[i] = m_mem[i][m_pc[i]];
            m_opc[i] = m_pc[i];
            m_ov[i]  = 1'b1;
            m_pc[i]  = (m_pc[i] + 1) % 256;
          end
        end
      end
      ST_HALT: begin
        if (redirect) begin
          m_pc[i] = int'(redirect_pc);
          m_ov[i] = 1'b0;
        end else if (out_ready) begin
          m_ov[i] = 1'b0;
        end
        if (start) m_st[i] = ST_RUN;
      end
      default: m_ov[i] = 1'b0;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < N; i++) step_model(i);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("model d%0d out_valid", i), 64'(d_ov[i]),  64'(m_ov[i]));
      check($sformatf("model d%0d state", i),     64'(d_st[i]),  64'(m_st[i]));
      check($sformatf("model d%0d fault", i),     64'(d_flt[i]), 64'(m_flt[i]));
      check($sformatf("model d%0d out_pc", i),    64'(d_pc[i]),  64'(m_opc[i]));
      check($sformatf("model d%0d out_instr", i), 64'(d_ins[i]), 64'(m_oin[i]));
    end
  endtask

  task automatic expect_out(string tag, int i, logic v, logic [7:0] pc, logic [31:0] ins);
    check($sformatf("%s d%0d valid", tag, i), 64'(d_ov[i]), 64'(v));
    if (v) begin
      check($sformatf("%s d%0d pc", tag, i),    64'(d_pc[i]),  64'(pc));
      check($sformatf("%s d%0d instr", tag, i), 64'(d_ins[i]), 64'(ins));
    end
  endtask

  task automatic expect_st(string tag, int i, logic [1:0] st, logic flt);
    check($sformatf("%s d%0d state", tag, i), 64'(d_st[i]),  64'(st));
    check($sformatf("%s d%0d fault", tag, i), 64'(d_flt[i]), 64'(flt));
  endtask

  task automatic write_word(logic [7:0] a, logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    cycle();
    prog_we = 1'b0;
  endtask

  task automatic run_table(string tag);
    for (int k = 0; k < 5; k++) begin
      start = tbl[k].start; out_ready = tbl[k].ready;
      cycle();
      for (int i = 0; i < N; i++)
        expect_out($sformatf("%s[%0d]", tag, k), i, tbl[k].exp_v, tbl[k].exp_pc, tbl[k].exp_instr);
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'd0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 8'd0, 32'h20080020};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'd1, 32'h20090037};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 8'd2, 32'h01098024};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'd3, 32'h01098025};

    // Reset state
    reset = 1'b0;
    cycle();
    for (int i = 0; i < N; i++) begin
      expect_st("reset", i, 2'b00, 1'b0);
      check($sformatf("reset d%0d valid", i), 64'(d_ov[i]),  64'd0);
      check($sformatf("reset d%0d pc", i),    64'(d_pc[i]),  64'd0);
      check($sformatf("reset d%0d instr", i), 64'(d_ins[i]), 64'd0);
    end
    reset = 1'b1;

    // Fill every word so no fetch ever reads uninitialised memory
    for (int k = 0; k < 256; k++) write_word(8'(k), {16'hA5A5, 8'h00, 8'(k)});
    write_word(8'd0, 32'h20080020);
    write_word(8'd1, 32'h20090037);
    write_word(8'd2, 32'h01098024);
    write_word(8'd3, 32'h01098025);

    // Test 1: start latency and sequential stream
    run_table("seq");

    // Test 2: stall holds word 1, release advances to word 2
    redirect = 1'b1; redirect_pc = 8'd1; out_ready = 1'b1;
    cycle();
    redirect = 1'b0; out_ready = 1'b0;
    cycle();
    expect_out("stall_fetch", 1, 1'b1, 8'd1, 32'h20090037);
    for (int k = 0; k < 3; k++) begin
      cycle();
      for (int i = 0; i < N; i++) expect_out("stall_hold", i, 1'b1, 8'd1, 32'h20090037);
    end
    out_ready = 1'b1;
    cycle();
    expect_out("stall_release", 0, 1'b1, 8'd2, 32'h01098024);

    // Test 3: redirect flushes a stalled word, one bubble
    out_ready = 1'b0;
    cycle();
    expect_out("stall2", 0, 1'b1, 8'd2, 32'h01098024);
    redirect = 1'b1; redirect_pc = 8'd0;
    cycle();
    expect_out("redir_flush", 0, 1'b0, 8'd0, 32'h0);
    redirect = 1'b0; out_ready = 1'b1;
    cycle();
    for (int i = 0; i < N; i++) expect_out("redir_target", i, 1'b1, 8'd0, 32'h20080020);

    // Test 4: out-of-range fault on DEPTH=20, sticky until reset
    redirect = 1'b1; redirect_pc = 8'd20;
    cycle();
    redirect = 1'b0;
    cycle();
    expect_st("fault", 0, 2'b11, 1'b1);
    expect_out("fault", 0, 1'b0, 8'd0, 32'h0);
    expect_out("d256_20", 1, 1'b1, 8'd20, 32'hA5A50014);
    start = 1'b1; redirect = 1'b1; redirect_pc = 8'd0;
    cycle();
    start = 1'b0; redirect = 1'b0;
    cycle();
    expect_st("fault_sticky", 0, 2'b11, 1'b1);
    expect_out("fault_sticky", 0, 1'b0, 8'd0, 32'h0);
    do_reset();
    expect_st("fault_reset", 0, 2'b00, 1'b0);

    // Wrap on the full-depth instance
    start = 1'b1;
    cycle();
    start = 1'b0; redirect = 1'b1; redirect_pc = 8'd255;
    cycle();
    redirect = 1'b0;
    cycle();
    expect_out("wrap255", 1, 1'b1, 8'd255, 32'hA5A500FF);
    cycle();
    expect_out("wrap0", 1, 1'b1, 8'd0, 32'h20080020);
    expect_st("wrap0", 1, 2'b01, 1'b0);

    // Test 5: halt, ignored program write, resume from saved pc
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    for (int i = 0; i < N; i++) begin
      expect_st("halt", i, 2'b10, 1'b0);
      expect_out("halt", i, 1'b0, 8'd0, 32'h0);
    end
    for (int k = 0; k < 2; k++) begin
      cycle();
      expect_out("halt_idle", 1, 1'b0, 8'd0, 32'h0);
    end
    write_word(8'd0, 32'hFFFFFFFF);
    start = 1'b1;
    cycle();
    start = 1'b0;
    expect_st("resume", 1, 2'b01, 1'b0);
    cycle();
    for (int i = 0; i < N; i++) expect_out("resume_pc", i, 1'b1, 8'd2, 32'h01098024);
    redirect = 1'b1; redirect_pc = 8'd0;
    cycle();
    redirect = 1'b0;
    cycle();
    for (int i = 0; i < N; i++) expect_out("mem_kept", i, 1'b1, 8'd0, 32'h20080020);

    // Test 6: reset mid-stream, memory retained
    do_reset();
    for (int i = 0; i < N; i++) begin
      expect_st("rst_run", i, 2'b00, 1'b0);
      check($sformatf("rst_run d%0d valid", i), 64'(d_ov[i]), 64'd0);
    end
    run_table("rerun");

    // Randomised stimulus against the reference model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset       = ($urandom_range(0, 99) >= 2);
      start       = ($urandom_range(0, 99) < 10);
      redirect    = ($urandom_range(0, 99) < 8);
      redirect_pc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 22));
      halt        = ($urandom_range(0, 99) < 5);
      out_ready   = ($urandom_range(0, 99) < 70);
      prog_we     = ($urandom_range(0, 99) < 20);
      prog_addr   = 8'($urandom_range(0, 31));
      prog_data   = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
